// File: rtl/mcr3_pkg.sv
// Shared definitions for the NVRAM upload reader: upload FSM states,
// the default ioctl slot and the fill byte returned outside the save area.
package mcr3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REQ,
    LAT
  } upload_state_e;

  localparam logic [7:0] NVRAM_INDEX = 8'd4;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;

  // Two's-complement checksum byte: adding it to the byte sum gives zero.
  function automatic logic [7:0] checksum_byte(input logic [7:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/nvram_upload_reader_if.sv
// HPS ioctl upload bus plus the save-RAM B-port request/grant bus.
// slave: the reader block; master: hps_io and the RAM arbiter side.
interface nvram_upload_reader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic              ioctl_rd;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_q;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, mem_gnt, mem_q,
    output ioctl_din, ioctl_wait, mem_req, mem_addr, mem_rd
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, mem_gnt, mem_q,
    input  ioctl_din, ioctl_wait, mem_req, mem_addr, mem_rd
  );
endinterface

// File: rtl/upload_lat_counter.sv
// Loadable down-counter covering the save-RAM read latency.
// load starts a count from RD_LAT; done pulses for one cycle when it hits 0.
module upload_lat_counter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  logic [2:0] cnt;
  logic       busy;

  assign done = busy && (cnt == '0);

  // Count down after a load; a fresh load always restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= 3'(RD_LAT);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 3'd1;
    end
  end
endmodule

// File: rtl/nvram_upload_reader.sv
// HPS upload responder: serves byte reads of the core save RAM while
// ioctl_upload is open for slot INDEX, sharing the RAM B port via req/gnt.
// Optional: define NVRAM_UPLOAD_CHECKSUM_EN to return a two's-complement
// checksum of the bytes read so far at ioctl_addr == DEPTH.
module nvram_upload_reader
  import mcr3_pkg::*;
#(
  parameter logic [7:0]  INDEX  = NVRAM_INDEX,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  nvram_upload_reader_if.slave   bus,
  output logic                   active,
  output logic                   overrun
);
  upload_state_e     state;
  logic              upload_q;
  logic              sess_open;
  logic              in_range;
  logic              lat_load;
  logic              lat_done;
  logic [7:0]        din_q;
  logic              wait_q;
  logic              req_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  logic [7:0]        sum;
  logic              at_depth;
  assign at_depth = (bus.ioctl_addr == 25'(DEPTH));
`endif

  assign sess_open = bus.ioctl_upload && !upload_q && (bus.ioctl_index == INDEX);
  assign in_range  = (bus.ioctl_addr < 25'(DEPTH));
  assign lat_load  = (state == REQ) && bus.mem_gnt && bus.ioctl_upload;

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_rd     = rd_q;
  assign bus.mem_addr   = addr_q;

  upload_lat_counter #(
    .RD_LAT (RD_LAT)
  ) u_lat (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .load  (lat_load),
    .done  (lat_done)
  );

  // Upload FSM; upload falling wins over everything, then session open,
  // so a read strobe coincident with the open is silently dropped.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      upload_q <= 1'b0;
      din_q    <= FILL_BYTE;
      wait_q   <= 1'b0;
      req_q    <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      active   <= 1'b0;
      overrun  <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      upload_q <= bus.ioctl_upload;
      rd_q     <= 1'b0;
      if (!bus.ioctl_upload) begin
        state  <= IDLE;
        active <= 1'b0;
        req_q  <= 1'b0;
        wait_q <= 1'b0;
      end else if (sess_open) begin
        state   <= ARMED;
        active  <= 1'b1;
        overrun <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
        sum     <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: ;
          ARMED: begin
            if (bus.ioctl_rd) begin
              if (in_range) begin
                addr_q <= bus.ioctl_addr[ADDR_W-1:0];
                wait_q <= 1'b1;
                req_q  <= 1'b1;
                state  <= REQ;
              end else begin
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                din_q <= at_depth ? checksum_byte(sum) : FILL_BYTE;
`else
                din_q <= FILL_BYTE;
`endif
              end
            end
          end
          REQ: begin
            if (bus.ioctl_rd) overrun <= 1'b1;
            if (bus.mem_gnt) begin
              rd_q  <= 1'b1;
              state <= LAT;
            end
          end
          LAT: begin
            if (bus.ioctl_rd) overrun <= 1'b1;
            if (lat_done) begin
              din_q  <= bus.mem_q;
              wait_q <= 1'b0;
              req_q  <= 1'b0;
              state  <= ARMED;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
              sum    <= sum + bus.mem_q;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nvram_upload_reader.sv
// Self-checking bench for nvram_upload_reader with a behavioural RAM and
// a reference model of read results, stall lengths and the checksum.
module tb_nvram_upload_reader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic active, overrun;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] ram [DEPTH];
  logic [7:0] pipe [RD_LAT];
  logic [7:0] sum_model;

  nvram_upload_reader_if #(.ADDR_W(ADDR_W)) bus ();

  nvram_upload_reader #(
    .INDEX  (8'd4),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .active  (active),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Save RAM: data appears RD_LAT registers after the sampled read strobe, then holds.
  always @(posedge clk) begin
    if (bus.mem_rd) pipe[0] <= ram[bus.mem_addr];
    for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_q = pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic open_session(input logic [7:0] idx);
    @(negedge clk);
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index  = idx;
    @(negedge clk);
    sum_model = 8'h00;
  endtask

  task automatic close_session();
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
  endtask

  // One read: gnt held off for d stall cycles, optional extra strobe at cycle ov.
  task automatic do_read(input logic [24:0] addr, input int unsigned d, input int unsigned ov,
                         output logic [7:0] din, output int unsigned waits,
                         output int unsigned rd_pulses, output int unsigned rd_at,
                         output logic req_ok, output logic [ADDR_W-1:0] addr_seen);
    @(negedge clk);
    bus.ioctl_addr = addr;
    bus.ioctl_rd   = 1'b1;
    bus.mem_gnt    = (d == 0);
    din = 8'h00; waits = 0; rd_pulses = 0; rd_at = 0; req_ok = 1'b1; addr_seen = '0;
    for (int unsigned k = 1; k < 64; k++) begin
      @(negedge clk);
      bus.ioctl_rd = (k == ov);
      if (k == 1) addr_seen = bus.mem_addr;
      if (bus.mem_rd) begin rd_pulses++; rd_at = k; end
      if (!bus.ioctl_wait) begin din = bus.ioctl_din; break; end
      waits++;
      if (!bus.mem_req) req_ok = 1'b0;
      bus.mem_gnt = (k > d);
    end
    bus.ioctl_rd = 1'b0;
    bus.mem_gnt  = 1'b0;
  endtask

  // Full checked read against the model.
  task automatic read_check(input string tag, input logic [24:0] addr, input int unsigned d,
                            input int unsigned ov);
    logic [7:0] din, exp;
    int unsigned waits, pulses, at;
    logic req_ok;
    logic [ADDR_W-1:0] aseen;
    logic [ADDR_W-1:0] alow;
    do_read(addr, d, ov, din, waits, pulses, at, req_ok, aseen);
    alow = addr[ADDR_W-1:0];
    if (addr < 25'(DEPTH)) begin
      exp = ram[alow];
      sum_model = sum_model + exp;
      check({tag, "_din"}, 32'(din), 32'(exp));
      check({tag, "_wait"}, waits, 2 + RD_LAT + d);
      check({tag, "_rdpulses"}, pulses, 1);
      check({tag, "_rdat"}, at, d + 2);
      check({tag, "_reqheld"}, 32'(req_ok), 1);
      check({tag, "_addr"}, 32'(aseen), 32'(alow));
    end else begin
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
      exp = (addr == 25'(DEPTH)) ? 8'(-sum_model) : 8'hFF;
`else
      exp = 8'hFF;
`endif
      check({tag, "_din"}, 32'(din), 32'(exp));
      check({tag, "_wait"}, waits, 0);
      check({tag, "_rdpulses"}, pulses, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] din_prev;
    logic any_req, din_ok;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'd0;
    bus.ioctl_addr   = '0;
    bus.ioctl_rd     = 1'b0;
    bus.mem_gnt      = 1'b0;
    sum_model        = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = 8'($urandom);
    for (int i = 0; i < int'(RD_LAT); i++) pipe[i] = 8'h00;
    ram[5] = 8'h3C;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_din", 32'(bus.ioctl_din), 32'hFF);
    check("rst_wait", 32'(bus.ioctl_wait), 0);
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_memrd", 32'(bus.mem_rd), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_active", 32'(active), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset_n = 1'b1;

    // Foreign slot is ignored
    open_session(8'd3);
    any_req = 1'b0; din_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ioctl_addr = 25'd5;
      bus.ioctl_rd   = (i % 2 == 0);
      bus.mem_gnt    = 1'b1;
      @(negedge clk);
      if (bus.mem_req) any_req = 1'b1;
      if (bus.ioctl_din !== 8'hFF) din_ok = 1'b0;
    end
    bus.ioctl_rd = 1'b0; bus.mem_gnt = 1'b0;
    check("idx3_active", 32'(active), 0);
    check("idx3_noreq", 32'(any_req), 0);
    check("idx3_din", 32'(din_ok), 1);
    close_session();

    // Basic reads, gnt immediate and withheld 7 cycles
    open_session(8'd4);
    check("open_active", 32'(active), 1);
    read_check("rd5", 25'd5, 0, 0);
    read_check("rd5_gnt7", 25'd5, 7, 0);

    // Out-of-range reads never touch RAM and never wrap
    read_check("oor1024", 25'd1024, 0, 0);
    read_check("oor2000", 25'd2000, 0, 0);
    read_check("oor_alias", 25'h400 + 25'd5, 0, 0);
    read_check("oor_top", 25'h1FFFFFF, 0, 0);

    // Random in-range and out-of-range reads
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0)
        read_check("rnd_oor", 25'($urandom_range(DEPTH + 1, 32'h1FFFFFF)), 0, 0);
      else
        read_check("rnd", 25'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 4), 0);
    end

    // Extra strobe during LAT
    read_check("ovr", 25'd9, 0, 2);
    check("ovr_flag", 32'(overrun), 1);
    read_check("ovr_next", 25'd10, 1, 0);
    check("ovr_sticky", 32'(overrun), 1);
    close_session();
    check("close_active", 32'(active), 0);
    open_session(8'd4);
    check("ovr_cleared", 32'(overrun), 0);

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    close_session();
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
    open_session(8'd4);
    for (int i = 0; i < 4; i++) read_check("cks_byte", 25'(i), 0, 0);
    read_check("cks", 25'd1024, 0, 0);
    check("cks_F6", 32'(bus.ioctl_din), 32'hF6);
    read_check("cks_above", 25'd1025, 0, 0);
`else
    read_check("nocks", 25'd1024, 0, 0);
`endif

    // Drop upload while in REQ
    read_check("pre_drop", 25'd20, 0, 0);
    din_prev = ram[20];
    @(negedge clk);
    bus.ioctl_addr = 25'd30; bus.ioctl_rd = 1'b1; bus.mem_gnt = 1'b0;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    check("drop_inreq", 32'(bus.mem_req), 1);
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    check("drop_req", 32'(bus.mem_req), 0);
    check("drop_wait", 32'(bus.ioctl_wait), 0);
    check("drop_active", 32'(active), 0);
    check("drop_din", 32'(bus.ioctl_din), 32'(din_prev));
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    check("drop_nord", 32'(bus.mem_rd), 0);
    bus.mem_gnt = 1'b0;

    // Open and strobe in the same cycle: strobe dropped, no overrun
    @(negedge clk);
    bus.ioctl_upload = 1'b1; bus.ioctl_index = 8'd4;
    bus.ioctl_addr = 25'd5; bus.ioctl_rd = 1'b1; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    check("same_active", 32'(active), 1);
    check("same_wait", 32'(bus.ioctl_wait), 0);
    check("same_req", 32'(bus.mem_req), 0);
    @(negedge clk);
    check("same_ovr", 32'(overrun), 0);
    bus.mem_gnt = 1'b0;
    sum_model = 8'h00;

    // Asynchronous reset in the middle of a fetch
    @(negedge clk);
    bus.ioctl_addr = 25'd7; bus.ioctl_rd = 1'b1; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    @(negedge clk);
    check("arst_pre_wait", 32'(bus.ioctl_wait), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_wait", 32'(bus.ioctl_wait), 0);
    check("arst_req", 32'(bus.mem_req), 0);
    check("arst_din", 32'(bus.ioctl_din), 32'hFF);
    check("arst_active", 32'(active), 0);
    check("arst_addr", 32'(bus.mem_addr), 0);
    bus.mem_gnt = 1'b0;
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
